// File: rtl/tlb_pkg.sv
// Shared types, encodings and helpers for the 16-entry joint TLB.
package tlb_pkg;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_NOP   = 2'b11
    } tlb_op_e;

    localparam int HI_VPN2_MSB = 31;
    localparam int HI_VPN2_LSB = 13;
    localparam int HI_ASID_MSB = 7;
    localparam int HI_ASID_LSB = 0;
    localparam int LO_PFN_MSB  = 25;
    localparam int LO_PFN_LSB  = 6;
    localparam int LO_C_MSB    = 5;
    localparam int LO_C_LSB    = 3;
    localparam int LO_D_BIT    = 2;
    localparam int LO_V_BIT    = 1;
    localparam int LO_G_BIT    = 0;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // The entry keeps a single global bit: both halves must be global.
    function automatic tlb_entry_t make_entry(input logic [31:0] hi, input logic [31:0] lo0,
                                              input logic [31:0] lo1);
        tlb_entry_t e;
        e.vpn2 = hi[HI_VPN2_MSB:HI_VPN2_LSB];
        e.asid = hi[HI_ASID_MSB:HI_ASID_LSB];
        e.g    = lo0[LO_G_BIT] & lo1[LO_G_BIT];
        e.pfn0 = lo0[LO_PFN_MSB:LO_PFN_LSB];
        e.c0   = lo0[LO_C_MSB:LO_C_LSB];
        e.d0   = lo0[LO_D_BIT];
        e.v0   = lo0[LO_V_BIT];
        e.pfn1 = lo1[LO_PFN_MSB:LO_PFN_LSB];
        e.c1   = lo1[LO_C_MSB:LO_C_LSB];
        e.d1   = lo1[LO_D_BIT];
        e.v1   = lo1[LO_V_BIT];
        return e;
    endfunction

    // Lowest set bit wins; an empty vector encodes to 0.
    function automatic logic [IDX_W-1:0] prio_index(input logic [TLBNUM-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // {pfn, c, d, v} of the even or odd page.
    function automatic logic [24:0] page_sel(input tlb_entry_t e, input logic odd);
        return odd ? {e.pfn1, e.c1, e.d1, e.v1} : {e.pfn0, e.c0, e.d0, e.v0};
    endfunction

endpackage

// File: rtl/tlb_if.sv
// WB/CP0 side of the TLB: instruction handshake, CP0 operands and results.
interface tlb_if;
    import tlb_pkg::*;

    logic             op_valid;
    logic [1:0]       op;
    logic [31:0]      op_pc;
    logic             op_ready;
    logic [31:0]      cp0_entryhi;
    logic [31:0]      cp0_entrylo0;
    logic [31:0]      cp0_entrylo1;
    logic [31:0]      cp0_index;
    logic             tlbp;
    logic             tlbp_found;
    logic [IDX_W-1:0] index;
    logic             tlbr;
    logic [18:0]      r_vpn2;
    logic [7:0]       r_asid;
    logic             r_g;
    logic [19:0]      r_pfn0;
    logic [2:0]       r_c0;
    logic             r_d0;
    logic             r_v0;
    logic [19:0]      r_pfn1;
    logic [2:0]       r_c1;
    logic             r_d1;
    logic             r_v1;
    logic             refetch;
    logic [31:0]      refetch_pc;

    modport master (
        output op_valid, op, op_pc, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
        input  op_ready, tlbp, tlbp_found, index, tlbr, r_vpn2, r_asid, r_g,
               r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1, refetch, refetch_pc
    );

    modport slave (
        input  op_valid, op, op_pc, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
        output op_ready, tlbp, tlbp_found, index, tlbr, r_vpn2, r_asid, r_g,
               r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1, refetch, refetch_pc
    );
endinterface

// File: rtl/tlb_match.sv
// Associative compare of one (vpn2, asid) against every entry.
module tlb_match
    import tlb_pkg::*;
(
    input  logic [18:0]                vpn2,
    input  logic [7:0]                 asid,
    input  tlb_entry_t [TLBNUM-1:0]    entries,
    output logic [TLBNUM-1:0]          match_vec,
    output logic                       found,
    output logic [IDX_W-1:0]           index
);

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            match_vec[i] = (entries[i].vpn2 == vpn2) &&
                           (entries[i].g || (entries[i].asid == asid));
        end
    end

    assign found = |match_vec;
    assign index = prio_index(match_vec);

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB with fetch/data search ports and a TLBP/TLBR/TLBWI sequencer.
//   state  | meaning
//   IDLE   | op_ready high; accepting op latches operands and performs the write
//   LOOKUP | priority-encode the registered probe vector
//   RESP   | tlbp/tlbr pulse with results, refetch pulse
module tlb_unit
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [18:0]      s0_vpn2,
    input  logic             s0_odd,
    input  logic [7:0]       s0_asid,
    output logic             s0_found,
    output logic [IDX_W-1:0] s0_index,
    output logic [19:0]      s0_pfn,
    output logic [2:0]       s0_c,
    output logic             s0_d,
    output logic             s0_v,
    input  logic [18:0]      s1_vpn2,
    input  logic             s1_odd,
    input  logic [7:0]       s1_asid,
    output logic             s1_found,
    output logic [IDX_W-1:0] s1_index,
    output logic [19:0]      s1_pfn,
    output logic [2:0]       s1_c,
    output logic             s1_d,
    output logic             s1_v,
    tlb_if.slave             bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    tlb_entry_t [TLBNUM-1:0] entries;
    logic [1:0]              state;
    tlb_op_e                 op_q;
    logic [TLBNUM-1:0]       match_q;
    logic                    found_q;
    logic [IDX_W-1:0]        idx_q;
    tlb_entry_t              rd_q;
    logic [31:0]             ret_pc_q;

    logic [IDX_W-1:0]        wr_idx;
    tlb_op_e                 op_in;
    logic [TLBNUM-1:0]       s0_vec, s1_vec, p_vec;
    logic                    p_found;
    logic [IDX_W-1:0]        p_index;
    logic                    unused_bits;

    assign wr_idx = bus.cp0_index[IDX_W-1:0];
    assign op_in  = tlb_op_e'(bus.op);

    tlb_match u_match_s0 (
        .vpn2(s0_vpn2), .asid(s0_asid), .entries(entries),
        .match_vec(s0_vec), .found(s0_found), .index(s0_index)
    );

    tlb_match u_match_s1 (
        .vpn2(s1_vpn2), .asid(s1_asid), .entries(entries),
        .match_vec(s1_vec), .found(s1_found), .index(s1_index)
    );

    tlb_match u_match_probe (
        .vpn2(bus.cp0_entryhi[HI_VPN2_MSB:HI_VPN2_LSB]),
        .asid(bus.cp0_entryhi[HI_ASID_MSB:HI_ASID_LSB]),
        .entries(entries),
        .match_vec(p_vec), .found(p_found), .index(p_index)
    );

    assign unused_bits = ^{s0_vec, s1_vec, p_found, p_index, bus.cp0_index[31:IDX_W]};

    assign {s0_pfn, s0_c, s0_d, s0_v} = s0_found ? page_sel(entries[s0_index], s0_odd) : '0;
    assign {s1_pfn, s1_c, s1_d, s1_v} = s1_found ? page_sel(entries[s1_index], s1_odd) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_TLBP;
            match_q  <= '0;
            found_q  <= 1'b0;
            idx_q    <= '0;
            rd_q     <= '0;
            ret_pc_q <= '0;
            entries  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        state    <= S_LOOKUP;
                        op_q     <= op_in;
                        ret_pc_q <= bus.op_pc + 32'd4;
                        case (op_in)
                            OP_TLBP:  match_q <= p_vec;
                            OP_TLBR:  rd_q    <= entries[wr_idx];
                            OP_TLBWI: entries[wr_idx] <= make_entry(bus.cp0_entryhi,
                                                                    bus.cp0_entrylo0,
                                                                    bus.cp0_entrylo1);
                            default:  ;
                        endcase
                    end
                end
                S_LOOKUP: begin
                    state <= S_RESP;
                    if (op_q == OP_TLBP) begin
                        found_q <= |match_q;
                        idx_q   <= prio_index(match_q);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.op_ready   = (state == S_IDLE);
    assign bus.tlbp       = (state == S_RESP) && (op_q == OP_TLBP);
    assign bus.tlbr       = (state == S_RESP) && (op_q == OP_TLBR);
    assign bus.refetch    = (state == S_RESP);
    assign bus.refetch_pc = ret_pc_q;
    assign bus.tlbp_found = found_q;
    assign bus.index      = idx_q;
    assign bus.r_vpn2     = rd_q.vpn2;
    assign bus.r_asid     = rd_q.asid;
    assign bus.r_g        = rd_q.g;
    assign bus.r_pfn0     = rd_q.pfn0;
    assign bus.r_c0       = rd_q.c0;
    assign bus.r_d0       = rd_q.d0;
    assign bus.r_v0       = rd_q.v0;
    assign bus.r_pfn1     = rd_q.pfn1;
    assign bus.r_c1       = rd_q.c1;
    assign bus.r_d1       = rd_q.d1;
    assign bus.r_v1       = rd_q.v1;

endmodule
